// File: rtl/execute_stage_if.sv
// ID/EX -> EX -> EX/MEM bus of the execute stage, including the multiply/divide busy flag.
// The slave modport is the execute stage itself; master is whatever drives ID/EX and consumes EX/MEM.
interface execute_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic        alu_src;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        ctrl_branch_in;
    logic        ctrl_memRead_in;
    logic        ctrl_memWrite_in;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] write_data;
    logic        ctrl_branch;
    logic        ctrl_memRead;
    logic        ctrl_memWrite;
    logic        out_valid;
    logic        md_busy;

    modport master (
        output in_valid, alu_op, alu_src, rs_data, rt_data, imm, shamt,
               ctrl_branch_in, ctrl_memRead_in, ctrl_memWrite_in,
        input  in_ready, alu_result, zero, write_data,
               ctrl_branch, ctrl_memRead, ctrl_memWrite, out_valid, md_busy
    );

    modport slave (
        input  in_valid, alu_op, alu_src, rs_data, rt_data, imm, shamt,
               ctrl_branch_in, ctrl_memRead_in, ctrl_memWrite_in,
        output in_ready, alu_result, zero, write_data,
               ctrl_branch, ctrl_memRead, ctrl_memWrite, out_valid, md_busy
    );
endinterface

// File: rtl/execute_stage.sv
// MIPS EX stage: operand select, ALU, EX/MEM pipeline register and an iterative
// unsigned multiply/divide unit owning HI/LO that stalls upstream while busy.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   MD_IDLE | no MULTU/DIVU in flight, stage accepts instructions
//   MD_MUL  | shift-add multiply, one multiplier bit per cycle
//   MD_DIV  | restoring divide, one quotient bit per cycle
module execute_stage #(
    parameter int MD_CYCLES = 32
) (
    input  logic           clk,
    input  logic           reset,
    execute_stage_if.slave ex
);
    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV} md_state_t;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SRA   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    md_state_t   r_state, w_state_nxt;
    logic [5:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_acc, w_acc_nxt;
    logic [31:0] r_q, w_q_nxt;
    logic [31:0] r_b, w_b_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;

    logic [31:0] r_alu_result, r_write_data;
    logic        r_zero, r_out_valid;
    logic        r_ctrl_branch, r_ctrl_memRead, r_ctrl_memWrite;

    logic [31:0] w_opb, w_result;
    logic        w_xfer, w_is_md;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic        w_div_ge;
    logic [31:0] w_div_rem;

    assign w_opb       = ex.alu_src ? ex.imm : ex.rt_data;
    assign ex.in_ready = (r_state == MD_IDLE);
    assign ex.md_busy  = (r_state != MD_IDLE);
    assign w_xfer      = ex.in_valid && ex.in_ready;
    assign w_is_md     = (ex.alu_op == OP_MULTU) || (ex.alu_op == OP_DIVU);

    always_comb begin
        w_result = '0;
        case (ex.alu_op)
            OP_AND:  w_result = ex.rs_data & w_opb;
            OP_OR:   w_result = ex.rs_data | w_opb;
            OP_NOR:  w_result = ~(ex.rs_data | w_opb);
            OP_ADD:  w_result = ex.rs_data + w_opb;
            OP_SUB:  w_result = ex.rs_data - w_opb;
            OP_SLT:  w_result = {31'd0, $signed(ex.rs_data) < $signed(w_opb)};
            OP_SLTU: w_result = {31'd0, ex.rs_data < w_opb};
            OP_SLL:  w_result = w_opb << ex.shamt;
            OP_SRL:  w_result = w_opb >> ex.shamt;
            OP_SRA:  w_result = $unsigned($signed(w_opb) >>> ex.shamt);
            OP_MFHI: w_result = r_hi;
            OP_MFLO: w_result = r_lo;
            default: w_result = '0;
        endcase
    end

    // r_acc/r_q hold {upper,lower} product in MUL and {remainder,quotient} in DIV
    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : 33'd0);
    assign w_div_shift = {r_acc, r_q[31]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
    assign w_div_rem   = w_div_ge ? (w_div_shift[31:0] - r_b) : w_div_shift[31:0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_q_nxt     = r_q;
        w_b_nxt     = r_b;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            MD_IDLE: begin
                if (w_xfer && w_is_md) begin
                    w_state_nxt = (ex.alu_op == OP_MULTU) ? MD_MUL : MD_DIV;
                    w_cnt_nxt   = 6'(MD_CYCLES);
                    w_acc_nxt   = '0;
                    w_q_nxt     = (ex.alu_op == OP_MULTU) ? w_opb : ex.rs_data;
                    w_b_nxt     = (ex.alu_op == OP_MULTU) ? ex.rs_data : w_opb;
                end
            end
            MD_MUL: begin
                w_cnt_nxt = r_cnt - 6'd1;
                w_acc_nxt = w_mul_sum[32:1];
                w_q_nxt   = {w_mul_sum[0], r_q[31:1]};
                if (r_cnt == 6'd1) begin
                    w_hi_nxt    = w_mul_sum[32:1];
                    w_lo_nxt    = {w_mul_sum[0], r_q[31:1]};
                    w_state_nxt = MD_IDLE;
                end
            end
            MD_DIV: begin
                w_cnt_nxt = r_cnt - 6'd1;
                w_acc_nxt = w_div_rem;
                w_q_nxt   = {r_q[30:0], w_div_ge};
                if (r_cnt == 6'd1) begin
                    w_hi_nxt    = w_div_rem;
                    w_lo_nxt    = {r_q[30:0], w_div_ge};
                    w_state_nxt = MD_IDLE;
                end
            end
            default: w_state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
            r_q     <= w_q_nxt;
            r_b     <= w_b_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Bubbles clear valid and controls but keep the datapath values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alu_result    <= '0;
            r_zero          <= 1'b0;
            r_write_data    <= '0;
            r_out_valid     <= 1'b0;
            r_ctrl_branch   <= 1'b0;
            r_ctrl_memRead  <= 1'b0;
            r_ctrl_memWrite <= 1'b0;
        end else if (w_xfer) begin
            r_alu_result    <= w_result;
            r_zero          <= (w_result == 32'd0);
            r_write_data    <= ex.rt_data;
            r_out_valid     <= 1'b1;
            r_ctrl_branch   <= ex.ctrl_branch_in   && !w_is_md;
            r_ctrl_memRead  <= ex.ctrl_memRead_in  && !w_is_md;
            r_ctrl_memWrite <= ex.ctrl_memWrite_in && !w_is_md;
        end else begin
            r_out_valid     <= 1'b0;
            r_ctrl_branch   <= 1'b0;
            r_ctrl_memRead  <= 1'b0;
            r_ctrl_memWrite <= 1'b0;
        end
    end

    assign ex.alu_result    = r_alu_result;
    assign ex.zero          = r_zero;
    assign ex.write_data    = r_write_data;
    assign ex.out_valid     = r_out_valid;
    assign ex.ctrl_branch   = r_ctrl_branch;
    assign ex.ctrl_memRead  = r_ctrl_memRead;
    assign ex.ctrl_memWrite = r_ctrl_memWrite;
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed spec cases plus a randomized stream checked
// against an arithmetic reference model of the ALU, HI/LO and EX/MEM register.
module tb_execute_stage;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SRA   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRL   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_MFLO  = 4'b1111;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    execute_stage_if bus();
    execute_stage #(.MD_CYCLES(32)) dut (.clk(clk), .reset(reset), .ex(bus));

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_hi = '0, m_lo = '0, m_res = '0, m_wd = '0;
    logic        m_zero = 1'b0, e_valid = 1'b0, e_br = 1'b0, e_mr = 1'b0, e_mw = 1'b0;

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh);
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_NOR:  return ~(a | b);
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return b << sh;
            OP_SRL:  return b >> sh;
            OP_SRA:  return $unsigned($signed(b) >>> sh);
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [68:0] obs();
        return {bus.out_valid, bus.zero, bus.ctrl_branch, bus.ctrl_memRead, bus.ctrl_memWrite,
                bus.alu_result, bus.write_data};
    endfunction

    function automatic logic [68:0] exp_v();
        return {e_valid, m_zero, e_br, e_mr, e_mw, m_res, m_wd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (!reset) begin
            e_valid = 0; e_br = 0; e_mr = 0; e_mw = 0; m_res = '0; m_wd = '0; m_zero = 0;
        end else begin
            e_valid = 0; e_br = 0; e_mr = 0; e_mw = 0;
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (bus.in_ready !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rt,
                         input logic [31:0] im, input logic src, input logic [4:0] sh,
                         input logic br, input logic mr, input logic mw);
        logic [31:0] b;
        logic [63:0] p;
        bit md;
        wait_ready();
        bus.alu_op = op; bus.rs_data = a; bus.rt_data = rt; bus.imm = im; bus.alu_src = src;
        bus.shamt = sh; bus.ctrl_branch_in = br; bus.ctrl_memRead_in = mr; bus.ctrl_memWrite_in = mw;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        b  = src ? im : rt;
        md = (op == OP_MULTU) || (op == OP_DIVU);
        m_res  = ref_alu(op, a, b, sh);
        m_zero = (m_res == 32'd0);
        m_wd   = rt;
        e_valid = 1; e_br = br && !md; e_mr = mr && !md; e_mw = mw && !md;
        if (op == OP_MULTU) begin
            p = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32]; m_lo = p[31:0];
        end else if (op == OP_DIVU) begin
            if (b == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
        end
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        #1;
        m_hi = '0; m_lo = '0; m_res = '0; m_wd = '0; m_zero = 0;
        e_valid = 0; e_br = 0; e_mr = 0; e_mw = 0;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid = 0; bus.alu_op = '0; bus.alu_src = 0; bus.rs_data = '0; bus.rt_data = '0;
        bus.imm = '0; bus.shamt = '0; bus.ctrl_branch_in = 0; bus.ctrl_memRead_in = 0;
        bus.ctrl_memWrite_in = 0;
        assert_reset();
        repeat (2) @(posedge clk);
        release_reset();
        issue(OP_OR, 32'h1234_0000, 32'h0000_5678, '0, 0, 0, 1, 1, 1);
        issue(OP_MULTU, 32'd7, 32'd6, '0, 0, 0, 0, 0, 0);
        wait_ready();
        assert_reset();
        n_vec++;
        if (obs() !== 69'd0 || bus.md_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h busy=%b required 0 busy=0", obs(), bus.md_busy);
        end
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b required 1", bus.in_ready);
        end
        release_reset();
        issue(OP_MFHI, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd0 || bus.zero !== 1'b1 || obs() !== exp_v()) begin
            n_err++;
            $display("FAIL reset_mfhi: got %h required %h", obs(), exp_v());
        end
    endtask

    task automatic test_arith();
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h55, 32'd1, 1, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd0 || bus.zero !== 1'b1 || obs() !== exp_v()) begin
            n_err++;
            $display("FAIL add_wrap: got %h zero=%b required 0 zero=1", bus.alu_result, bus.zero);
        end
        issue(OP_SUB, 32'd5, 32'd7, 32'd0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'hFFFF_FFFE || bus.zero !== 1'b0) begin
            n_err++;
            $display("FAIL sub: got %h required fffffffe", bus.alu_result);
        end
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd1) begin
            n_err++;
            $display("FAIL slt: got %h required 1", bus.alu_result);
        end
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd0, 32'd1, 1, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd0 || bus.zero !== 1'b1) begin
            n_err++;
            $display("FAIL sltu: got %h required 0", bus.alu_result);
        end
        issue(OP_SRA, 32'd0, 32'h8000_0000, 32'd0, 0, 5'd4, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'hF800_0000) begin
            n_err++;
            $display("FAIL sra: got %h required f8000000", bus.alu_result);
        end
    endtask

    task automatic test_passthrough();
        issue(OP_ADD, 32'h10, 32'hDEAD_BEEF, 32'd4, 1, 0, 0, 0, 1);
        n_vec++;
        if (bus.alu_result !== 32'h14 || bus.write_data !== 32'hDEAD_BEEF ||
            bus.ctrl_memWrite !== 1'b1 || bus.out_valid !== 1'b1 || obs() !== exp_v()) begin
            n_err++;
            $display("FAIL store_pass: got %h required %h", obs(), exp_v());
        end
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.ctrl_memWrite !== 1'b0 || bus.alu_result !== 32'h14 ||
            bus.write_data !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL bubble: got %h required %h", obs(), exp_v());
        end
    endtask

    task automatic test_multu();
        int cnt = 0;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 0, 0, 1, 1, 1);
        n_vec++;
        if (bus.alu_result !== 32'd0 || bus.zero !== 1'b1 || bus.out_valid !== 1'b1 ||
            {bus.ctrl_branch, bus.ctrl_memRead, bus.ctrl_memWrite} !== 3'b000 || bus.md_busy !== 1'b1) begin
            n_err++;
            $display("FAIL md_entry: got %h busy=%b required %h busy=1", obs(), bus.md_busy, exp_v());
        end
        while (bus.in_ready !== 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL busy_cycles: got %0d required 32", cnt);
        end
        issue(OP_MFHI, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'hFFFF_FFFE) begin
            n_err++;
            $display("FAIL mul_hi: got %h required fffffffe", bus.alu_result);
        end
        issue(OP_MFLO, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL mul_lo: got %h required 00000001", bus.alu_result);
        end
    endtask

    task automatic test_divu();
        issue(OP_DIVU, 32'd100, 32'd7, '0, 0, 0, 0, 0, 0);
        issue(OP_MFLO, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd14) begin
            n_err++;
            $display("FAIL div_lo: got %h required 0000000e", bus.alu_result);
        end
        issue(OP_MFHI, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd2) begin
            n_err++;
            $display("FAIL div_hi: got %h required 00000002", bus.alu_result);
        end
        issue(OP_DIVU, 32'd9, 32'd0, '0, 0, 0, 0, 0, 0);
        issue(OP_MFLO, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL div0_lo: got %h required ffffffff", bus.alu_result);
        end
        issue(OP_MFHI, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd9) begin
            n_err++;
            $display("FAIL div0_hi: got %h required 00000009", bus.alu_result);
        end
    endtask

    task automatic test_reset_mid_md();
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, '0, 0, 0, 0, 0, 0);
        repeat (9) tick();
        assert_reset();
        n_vec++;
        if (bus.md_busy !== 1'b0 || bus.in_ready !== 1'b1 || obs() !== 69'd0) begin
            n_err++;
            $display("FAIL mid_md_reset: got %h busy=%b required 0 busy=0", obs(), bus.md_busy);
        end
        release_reset();
        issue(OP_MFHI, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd0) begin
            n_err++;
            $display("FAIL mid_md_hi: got %h required 0", bus.alu_result);
        end
        issue(OP_MFLO, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd0) begin
            n_err++;
            $display("FAIL mid_md_lo: got %h required 0", bus.alu_result);
        end
        issue(OP_MULTU, 32'd3, 32'd4, '0, 0, 0, 0, 0, 0);
        issue(OP_MFLO, '0, '0, '0, 0, 0, 0, 0, 0);
        n_vec++;
        if (bus.alu_result !== 32'd12) begin
            n_err++;
            $display("FAIL fresh_mul: got %h required 0000000c", bus.alu_result);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, rt, im;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                tick();
                n_vec++;
                if (obs() !== exp_v()) begin
                    n_err++;
                    $display("FAIL rand_bubble[%0d]: got %h required %h", i, obs(), exp_v());
                end
            end else begin
                op = 4'($urandom_range(0, 15));
                a  = $urandom();
                rt = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
                im = ($urandom_range(0, 3) == 0) ? a : $urandom();
                issue(op, a, rt, im, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                n_vec++;
                if (obs() !== exp_v()) begin
                    n_err++;
                    $display("FAIL rand_op[%0d] op=%b: got %h required %h", i, op, obs(), exp_v());
                end
                if (op == OP_MULTU || op == OP_DIVU) begin
                    issue(($urandom_range(0, 1) == 1) ? OP_MFHI : OP_MFLO, '0, '0, '0, 0, 0, 0, 0, 0);
                    n_vec++;
                    if (obs() !== exp_v()) begin
                        n_err++;
                        $display("FAIL rand_mf[%0d]: got %h required %h", i, obs(), exp_v());
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arith();
        test_passthrough();
        test_multu();
        test_divu();
        test_reset_mid_md();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
